// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_DATA_W = 32;
    localparam logic [IF_DATA_W-1:0] IF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        KILL  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic                 valid;
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_ADDR_W-1:0] pc4;
        logic [IF_DATA_W-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_fetch_stage_hold_buf.sv
// Single-entry {pc, instr} buffer that parks a fetched instruction while decode is stalled.
module if_hold_buf
    import if_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int DATA_W = IF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [DATA_W-1:0] load_instr,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC/request FSM for a one-outstanding imem, plus the IF/ID register.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int                ADDR_W    = IF_ADDR_W,
    parameter int                DATA_W    = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_hazard,
    input  logic              if_flush,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic [DATA_W-1:0] if_id_instr
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              hold_valid;
    logic [ADDR_W-1:0] hold_pc;
    logic [DATA_W-1:0] hold_instr;
    logic              resp_live;
    logic              hold_load;
    logic              hold_drain;
    logic              issue;

    // A response that lands during a stall is parked, and fetching pauses until it drains.
    always_comb begin
        resp_live  = (state == WAIT) && imem_ack && !if_flush;
        hold_load  = resp_live && !data_hazard;
        hold_drain = data_hazard && hold_valid && !if_flush;
        issue      = ((state == FETCH) || ((state == WAIT) && imem_ack))
                     && !hold_valid && !if_flush && !hold_load;
    end

    if_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (hold_load),
        .drain      (hold_drain),
        .clear      (if_flush),
        .load_pc    (req_pc),
        .load_instr (imem_rdata),
        .valid      (hold_valid),
        .pc         (hold_pc),
        .instr      (hold_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            req_pc    <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            imem_req <= issue;
            if (issue) begin
                imem_addr <= pc;
            end
            if (if_flush) begin
                pc <= redirect_pc;
                // An in-flight request without its ack must still be absorbed in KILL.
                case (state)
                    WAIT:    state <= imem_ack ? FETCH : KILL;
                    KILL:    state <= imem_ack ? FETCH : KILL;
                    default: state <= FETCH;
                endcase
            end else if (issue) begin
                pc     <= pc + ADDR_W'(4);
                req_pc <= pc;
                state  <= WAIT;
            end else if ((state != FETCH) && imem_ack) begin
                state <= FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (if_flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (data_hazard) begin
            if (hold_valid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= hold_pc;
                if_id_pc4   <= hold_pc + ADDR_W'(4);
                if_id_instr <= hold_instr;
            end else if (resp_live) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= req_pc;
                if_id_pc4   <= req_pc + ADDR_W'(4);
                if_id_instr <= imem_rdata;
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: cycle table plus scoreboarded latency/reset sequences.
module tb_if_fetch_stage;
    import if_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_hazard;
    logic        if_flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;

    int checks   = 0;
    int failures = 0;

    if_fetch_stage #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_hazard (data_hazard),
        .if_flush    (if_flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dh;
        logic        fl;
        logic [31:0] redir;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vec[20];
    logic [31:0] req_q[$];
    if_id_t      ifid_q[$];

    // memory model state
    int          lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    if_id_t snap = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    function automatic if_id_t mk(input logic [31:0] p);
        if_id_t e;
        e.valid = 1'b1;
        e.pc    = p;
        e.pc4   = p + 32'd4;
        e.instr = instr_of(p);
        return e;
    endfunction

    function automatic vec_t row(input logic dh, input logic fl, input logic [31:0] redir,
                                 input logic er, input logic [31:0] ea,
                                 input logic ev, input logic [31:0] ep);
        vec_t r;
        r.dh = dh; r.fl = fl; r.redir = redir;
        r.exp_req = er; r.exp_addr = ea; r.exp_valid = ev; r.exp_pc = ep;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [31:0] ea;
        if_id_t      e;
        if (imem_req) begin
            if (req_q.size() == 0) chk("req_unexpected", imem_addr, 32'hFFFF_FFFF);
            else begin
                ea = req_q.pop_front();
                chk("req_addr", imem_addr, ea);
            end
        end
        if (!if_id_valid) begin
            chk("bubble_instr", if_id_instr, NOP);
        end else if (data_hazard) begin
            if (ifid_q.size() == 0) chk("ifid_unexpected", if_id_pc, 32'hFFFF_FFFF);
            else begin
                e = ifid_q.pop_front();
                chk("ifid_pc", if_id_pc, e.pc);
                chk("ifid_pc4", if_id_pc4, e.pc4);
                chk("ifid_instr", if_id_instr, e.instr);
            end
        end else begin
            chk("held_valid", {31'd0, snap.valid}, 32'd1);
            chk("held_pc", if_id_pc, snap.pc);
            chk("held_instr", if_id_instr, snap.instr);
        end
        snap = '{if_id_valid, if_id_pc, if_id_pc4, if_id_instr};
    endtask

    // Ack arrives in the lat-th cycle counting the request-pulse cycle as the first.
    task automatic mem_tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_0000;
        if (pend) begin
            cnt--;
            if (cnt <= 0) begin
                imem_ack = 1'b1; imem_rdata = instr_of(paddr); pend = 1'b0;
            end
        end
        if (imem_req) begin
            pend = 1'b1; paddr = imem_addr; cnt = lat - 1;
            if (cnt <= 0) begin
                imem_ack = 1'b1; imem_rdata = instr_of(paddr); pend = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        monitor();
        mem_tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = row(1, 0, 32'h000, 1, 32'h000, 0, 32'h000);
        vec[1]  = row(1, 0, 32'h000, 1, 32'h004, 1, 32'h000);
        vec[2]  = row(1, 0, 32'h000, 1, 32'h008, 1, 32'h004);
        vec[3]  = row(0, 0, 32'h000, 0, 32'h000, 1, 32'h004);
        vec[4]  = row(0, 0, 32'h000, 0, 32'h000, 1, 32'h004);
        vec[5]  = row(1, 0, 32'h000, 0, 32'h000, 1, 32'h008);
        vec[6]  = row(1, 0, 32'h000, 1, 32'h00C, 0, 32'h000);
        vec[7]  = row(1, 0, 32'h000, 1, 32'h010, 1, 32'h00C);
        vec[8]  = row(1, 1, 32'h100, 0, 32'h000, 0, 32'h000);
        vec[9]  = row(1, 0, 32'h000, 1, 32'h100, 0, 32'h000);
        vec[10] = row(1, 0, 32'h000, 1, 32'h104, 1, 32'h100);
        vec[11] = row(0, 1, 32'h200, 0, 32'h000, 0, 32'h000);
        vec[12] = row(1, 0, 32'h000, 1, 32'h200, 0, 32'h000);
        vec[13] = row(1, 0, 32'h000, 1, 32'h204, 1, 32'h200);
        vec[14] = row(0, 0, 32'h000, 0, 32'h000, 1, 32'h200);
        vec[15] = row(0, 1, 32'h300, 0, 32'h000, 0, 32'h000);
        vec[16] = row(1, 0, 32'h000, 1, 32'h300, 0, 32'h000);
        vec[17] = row(1, 0, 32'h000, 1, 32'h304, 1, 32'h300);
        vec[18] = row(1, 0, 32'h000, 1, 32'h308, 1, 32'h304);
        vec[19] = row(1, 1, 32'h400, 0, 32'h000, 0, 32'h000);

        rst_n = 1'b0; data_hazard = 1'b1; if_flush = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd0);
        chk("rst_instr", if_id_instr, NOP);
        rst_n = 1'b1;

        // zero-wait memory: streaming, stall/hold, flush cases
        for (int i = 0; i < 20; i++) begin
            data_hazard = vec[i].dh; if_flush = vec[i].fl; redirect_pc = vec[i].redir;
            if (vec[i].exp_req) req_q.push_back(vec[i].exp_addr);
            if (vec[i].exp_valid && vec[i].dh) ifid_q.push_back(mk(vec[i].exp_pc));
            step();
            chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vec[i].exp_req});
            chk($sformatf("vec%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vec[i].exp_valid});
            if (vec[i].exp_valid) chk($sformatf("vec%0d_pc", i), if_id_pc, vec[i].exp_pc);
        end
        if_flush = 1'b0;
        chk("vec_req_left", req_q.size(), 0);
        chk("vec_ifid_left", ifid_q.size(), 0);
        req_q.delete(); ifid_q.delete();

        // 3-cycle memory, flush while waiting: the 0x400 response must be dropped
        lat = 3; data_hazard = 1'b1;
        req_q.push_back(32'h400); req_q.push_back(32'h100); req_q.push_back(32'h104);
        ifid_q.push_back(mk(32'h100));
        step();
        step();
        if_flush = 1'b1; redirect_pc = 32'h100;
        step();
        if_flush = 1'b0;
        step();
        chk("kill_drop_valid", {31'd0, if_id_valid}, 32'd0);
        for (int n = 0; n < 12 && ifid_q.size() != 0; n++) step();
        chk("lat3_ifid_left", ifid_q.size(), 0);
        chk("lat3_req_left", req_q.size(), 0);

        // async reset while a request is in flight
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_pc", if_id_pc, 32'd0);
        chk("arst_instr", if_id_instr, NOP);
        pend = 1'b0; imem_ack = 1'b0; snap = '0;
        req_q.delete(); ifid_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat = 1;
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        req_q.push_back(32'h0); req_q.push_back(32'h4); req_q.push_back(32'h8);
        ifid_q.push_back(mk(32'h0)); ifid_q.push_back(mk(32'h4));
        step();
        chk("stray_ack_valid", {31'd0, if_id_valid}, 32'd0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        step();
        step();
        chk("post_rst_ifid_left", ifid_q.size(), 0);
        chk("post_rst_req_left", req_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
